// File: rtl/assign_station_multi_pkg.sv
// assign_station_multi_pkg: shared entry states, tag/packet field widths and swizzle codes.
package assign_station_multi_pkg;

    localparam int TAG_EXT_W = 4;
    localparam int DST_W     = 8;
    localparam int SWZ_W     = 2;
    localparam logic [SWZ_W-1:0] SWZ_ZERO = 2'd3;

    typedef enum logic [2:0] {
        ST_FREE,
        ST_WAIT,
        ST_READY,
        ST_EXEC,
        ST_DONE
    } entry_state_t;

    // Tag = {station id, entry index}; the index always occupies TAG_EXT_W bits.
    function automatic int tag_width(input int id_w);
        return id_w + TAG_EXT_W;
    endfunction

endpackage

// File: rtl/assign_station_multi_entry.sv
// assign_station_entry: one station slot -- operand wait/capture (with lane swizzle) and
// the FREE/WAIT/READY/EXEC/DONE life cycle.
module assign_station_entry
    import assign_station_multi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 3,
    parameter int TAG_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_load,
    input  logic                         i_src_ready,
    input  logic [TAG_W-1:0]             i_src_tag,
    input  logic [LANES*DATA_WIDTH-1:0]  i_value,
    input  logic [LANES*SWZ_W-1:0]       i_swizzle,
    input  logic [DST_W-1:0]             i_dst,
    input  logic [LANES-1:0]             i_we,
    input  logic                         i_commit_valid,
    input  logic [TAG_W-1:0]             i_commit_tag,
    input  logic [LANES*DATA_WIDTH-1:0]  i_commit_data,
    input  logic                         i_free,
    output entry_state_t                 o_state,
    output logic [DST_W-1:0]             o_dst,
    output logic [LANES-1:0]             o_we,
    output logic [LANES*DATA_WIDTH-1:0]  o_data
);

    entry_state_t                  r_state;
    logic [TAG_W-1:0]              r_tag;
    logic [LANES*SWZ_W-1:0]        r_swz;
    logic [DST_W-1:0]              r_dst;
    logic [LANES-1:0]              r_we;
    logic [LANES*DATA_WIDTH-1:0]   r_data;
    logic                          w_idle;
    logic                          w_hit_new;
    logic                          w_hit_old;
    logic [LANES*SWZ_W-1:0]        w_sel;
    logic [LANES*DATA_WIDTH-1:0]   w_raw;
    logic [LANES*DATA_WIDTH-1:0]   w_cap;

    assign w_idle    = r_state == ST_FREE;
    assign w_hit_new = i_commit_valid && i_commit_tag == i_src_tag;
    assign w_hit_old = i_commit_valid && i_commit_tag == r_tag;
    // While FREE the swizzle/operand come from the issue port, afterwards from the stored select and the bus.
    assign w_sel     = w_idle ? i_swizzle : r_swz;
    assign w_raw     = (w_idle && i_src_ready) ? i_value : i_commit_data;

    genvar k;
    for (k = 0; k < LANES; k++) begin : g_lane
        logic [SWZ_W-1:0] w_s;
        assign w_s = w_sel[k*SWZ_W +: SWZ_W];
        assign w_cap[k*DATA_WIDTH +: DATA_WIDTH] = (w_s == SWZ_ZERO || int'(w_s) >= LANES) ? '0
                                                 : w_raw[int'(w_s)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FREE;
            r_tag   <= '0;
            r_swz   <= '0;
            r_dst   <= '0;
            r_we    <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_FREE: if (i_load) begin
                    r_tag   <= i_src_tag;
                    r_swz   <= i_swizzle;
                    r_dst   <= i_dst;
                    r_we    <= i_we;
                    r_data  <= w_cap;
                    r_state <= (i_src_ready || w_hit_new) ? ST_READY : ST_WAIT;
                end
                ST_WAIT: if (w_hit_old) begin
                    r_data  <= w_cap;
                    r_state <= ST_READY;
                end
                ST_READY: r_state <= ST_EXEC;
                ST_EXEC:  r_state <= ST_DONE;
                ST_DONE:  if (i_free) r_state <= ST_FREE;
                default:  r_state <= ST_FREE;
            endcase
        end
    end

    assign o_state = r_state;
    assign o_dst   = r_dst;
    assign o_we    = r_we;
    assign o_data  = r_data;

endmodule

// File: rtl/assign_station_multi.sv
// assign_station_multi: multi-entry assign station with age-ordered commit arbitration.
// Optional ASSIGN_STATION_SWIZZLE_EN adds the iIssueSwizzle per-lane source select port.
module assign_station_multi
    import assign_station_multi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 3,
    parameter int DEPTH      = 4,
    parameter int ID_WIDTH   = 4,
    parameter logic [ID_WIDTH-1:0] MY_ID = 4'b0010
) (
    input  logic                               Clock,
    input  logic                               Reset,
    input  logic                               iIssueValid,
    input  logic [DST_W-1:0]                   iIssueDst,
    input  logic [LANES-1:0]                   iIssueWE,
    input  logic                               iIssueSrcReady,
    input  logic [ID_WIDTH+TAG_EXT_W-1:0]      iIssueSrcTag,
    input  logic [LANES*DATA_WIDTH-1:0]        iIssueValue,
`ifdef ASSIGN_STATION_SWIZZLE_EN
    input  logic [LANES*SWZ_W-1:0]             iIssueSwizzle,
`endif
    input  logic                               iCommitValid,
    input  logic [ID_WIDTH+TAG_EXT_W-1:0]      iCommitTag,
    input  logic [LANES*DATA_WIDTH-1:0]        iCommitBusData,
    output logic                               oCommitRequest,
    input  logic                               iCommitGranted,
    output logic [ID_WIDTH+TAG_EXT_W-1:0]      oCommitId,
    output logic [DST_W-1:0]                   oCommitDst,
    output logic [LANES-1:0]                   oCommitWE,
    output logic [LANES*DATA_WIDTH-1:0]        oCommitData,
    output logic                               oBusy
);

    localparam int TW = tag_width(ID_WIDTH);
    localparam int W  = LANES * DATA_WIDTH;

    entry_state_t           w_state [DEPTH];
    logic [DST_W-1:0]       w_dst   [DEPTH];
    logic [LANES-1:0]       w_we    [DEPTH];
    logic [W-1:0]           w_data  [DEPTH];
    logic [DEPTH-1:0]       w_free;
    logic [DEPTH-1:0]       w_done;
    logic [DEPTH-1:0]       w_load;
    logic [DEPTH-1:0]       w_sel;
    logic [DEPTH-1:0]       w_gnt;
    logic [DEPTH-1:0]       w_free_nxt;
    logic [LANES*SWZ_W-1:0] w_swz;
    logic                   w_issue;
    logic [DEPTH-1:0]       r_older [DEPTH];
    logic                   r_busy;

`ifdef ASSIGN_STATION_SWIZZLE_EN
    assign w_swz = iIssueSwizzle;
`else
    genvar k;
    for (k = 0; k < LANES; k++) begin : g_ident
        assign w_swz[k*SWZ_W +: SWZ_W] = SWZ_W'(k);
    end
`endif

    assign w_issue = iIssueValid && !r_busy;

    always_comb begin
        w_load = '0;
        for (int i = 0; i < DEPTH; i++)
            if (w_free[i] && w_load == '0) w_load[i] = w_issue;
    end

    // r_older[j][i] set means entry j was issued before entry i; the oldest DONE has no older DONE peer.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_sel[i] = w_done[i];
            for (int j = 0; j < DEPTH; j++)
                if (w_done[j] && r_older[j][i]) w_sel[i] = 1'b0;
        end
    end

    assign w_gnt      = w_sel & {DEPTH{iCommitGranted}};
    assign w_free_nxt = (w_free & ~w_load) | w_gnt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_busy <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
        end else begin
            r_busy <= ~|w_free_nxt;
            for (int n = 0; n < DEPTH; n++) begin
                if (w_load[n]) begin
                    r_older[n] <= '0;
                    for (int j = 0; j < DEPTH; j++) r_older[j][n] <= (j != n);
                end
            end
        end
    end

    genvar e;
    for (e = 0; e < DEPTH; e++) begin : g_entry
        assign_station_entry #(
            .DATA_WIDTH(DATA_WIDTH),
            .LANES     (LANES),
            .TAG_W     (TW)
        ) u_entry (
            .clk           (Clock),
            .rst           (Reset),
            .i_load        (w_load[e]),
            .i_src_ready   (iIssueSrcReady),
            .i_src_tag     (iIssueSrcTag),
            .i_value       (iIssueValue),
            .i_swizzle     (w_swz),
            .i_dst         (iIssueDst),
            .i_we          (iIssueWE),
            .i_commit_valid(iCommitValid),
            .i_commit_tag  (iCommitTag),
            .i_commit_data (iCommitBusData),
            .i_free        (w_gnt[e]),
            .o_state       (w_state[e]),
            .o_dst         (w_dst[e]),
            .o_we          (w_we[e]),
            .o_data        (w_data[e])
        );
        assign w_free[e] = w_state[e] == ST_FREE;
        assign w_done[e] = w_state[e] == ST_DONE;
    end

    assign oCommitRequest = |w_done;
    assign oBusy          = r_busy;

    always_comb begin
        oCommitId   = '0;
        oCommitDst  = '0;
        oCommitWE   = '0;
        oCommitData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel[i]) begin
                oCommitId   = {MY_ID, TAG_EXT_W'(i)};
                oCommitDst  = w_dst[i];
                oCommitWE   = w_we[i];
                oCommitData = w_data[i];
            end
        end
    end

endmodule
